// File: rtl/alu_exec_stage.sv
// Execute stage around an external combinational ALU: operand drive, result
// select, Z/N/C/V flag generation and a registered writeback beat.
// MUL emits two writeback beats (lo to rd, then hi to rd+1).
module alu_exec_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RD_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   // issue side
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic [RD_W-1:0] in_rd,
   // ALU operand drive
   output logic [XLEN-1:0] alu_x,
   output logic [XLEN-1:0] alu_y,
   output logic            alu_carry,
   // ALU results
   input  logic [XLEN-1:0] alu_summ,
   input  logic [XLEN-1:0] alu_mult_h,
   input  logic [XLEN-1:0] alu_mult_l,
   input  logic [XLEN-1:0] alu_zand,
   input  logic [XLEN-1:0] alu_zor,
   input  logic [XLEN-1:0] alu_zxor,
   input  logic [XLEN-1:0] alu_znot,
   input  logic [XLEN-1:0] alu_sub,
   input  logic [XLEN-1:0] alu_ashiftl,
   input  logic [XLEN-1:0] alu_ashiftr,
   input  logic [XLEN-1:0] alu_lshiftl,
   input  logic [XLEN-1:0] alu_lshiftr,
   input  logic [XLEN-1:0] alu_revers,
   input  logic            alu_ocarry,
   // writeback side
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_we,
   output logic [RD_W-1:0] out_rd,
   output logic [XLEN-1:0] out_data,
   output logic [3:0]      flags
);

   localparam int unsigned MSB = XLEN - 1;
   localparam int unsigned EW  = XLEN + 2;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBC = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_ASL = 4'd8;
   localparam logic [3:0] OP_ASR = 4'd9;
   localparam logic [3:0] OP_LSL = 4'd10;
   localparam logic [3:0] OP_LSR = 4'd11;
   localparam logic [3:0] OP_REV = 4'd12;
   localparam logic [3:0] OP_MUL = 4'd13;
   localparam logic [3:0] OP_MOV = 4'd14;
   localparam logic [3:0] OP_CMP = 4'd15;

   typedef enum logic {IDLE, MULHI} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [RD_W-1:0] hi_rd_q, hi_rd_d;
   logic            valid_d, we_d;
   logic [RD_W-1:0] rd_d;
   logic [XLEN-1:0] data_d;
   logic [3:0]      flags_d;

   logic [XLEN-1:0] res_c;
   logic            we_c, c_c, v_c, z_c, n_c, upd_cv_c;
   logic [3:0]      flags_c;
   logic [EW-1:0]   sub_lhs_c, sub_rhs_c;
   logic            accept, out_hs;

   // Operand pass-through and carry-in selection
   assign alu_x     = in_a;
   assign alu_y     = in_b;
   assign alu_carry = ((in_op == OP_ADC) || (in_op == OP_SBC)) ? flags[1] : 1'b0;

   // Issue/writeback handshakes; MUL hi beat blocks new issue
   assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid && out_ready;

   // Result select and flag generation for the issuing op
   always_comb begin
      res_c     = '0;
      we_c      = 1'b1;
      c_c       = flags[1];
      v_c       = flags[0];
      upd_cv_c  = 1'b0;
      sub_lhs_c = {2'b00, in_a};
      sub_rhs_c = {2'b00, in_b} + EW'((in_op == OP_SBC) ? ~flags[1] : 1'b0);
      case (in_op)
         OP_ADD, OP_ADC: begin
            res_c    = alu_summ;
            upd_cv_c = 1'b1;
         end
         OP_SUB, OP_SBC, OP_CMP: begin
            res_c    = alu_sub;
            upd_cv_c = 1'b1;
            we_c     = (in_op != OP_CMP);
         end
         OP_AND:  res_c = alu_zand;
         OP_OR:   res_c = alu_zor;
         OP_XOR:  res_c = alu_zxor;
         OP_NOT:  res_c = alu_znot;
         OP_ASL:  res_c = alu_ashiftl;
         OP_ASR:  res_c = alu_ashiftr;
         OP_LSL:  res_c = alu_lshiftl;
         OP_LSR:  res_c = alu_lshiftr;
         OP_REV:  res_c = alu_revers;
         OP_MUL:  res_c = alu_mult_l;
         default: res_c = in_b;
      endcase
      if ((in_op == OP_ADD) || (in_op == OP_ADC)) begin
         c_c = alu_ocarry;
         v_c = (in_a[MSB] == in_b[MSB]) && (res_c[MSB] != in_a[MSB]);
      end else if (upd_cv_c) begin
         c_c = (sub_lhs_c >= sub_rhs_c);
         v_c = (in_a[MSB] != in_b[MSB]) && (res_c[MSB] != in_a[MSB]);
      end
      if (in_op == OP_MUL) begin
         z_c = ({alu_mult_h, alu_mult_l} == '0);
         n_c = alu_mult_h[MSB];
      end else begin
         z_c = (res_c == '0);
         n_c = res_c[MSB];
      end
      flags_c = (in_op == OP_MOV) ? flags : {z_c, n_c, c_c, v_c};
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      hi_rd_d = hi_rd_q;
      valid_d = out_valid;
      we_d    = out_we;
      rd_d    = out_rd;
      data_d  = out_data;
      flags_d = flags;
      if (accept) begin
         valid_d = 1'b1;
         we_d    = we_c;
         rd_d    = in_rd;
         data_d  = res_c;
         flags_d = flags_c;
         if (in_op == OP_MUL) begin
            hi_d    = alu_mult_h;
            hi_rd_d = in_rd + RD_W'(1);
            state_d = MULHI;
         end
      end else if (out_hs) begin
         if (state_q == MULHI) begin
            data_d  = hi_q;
            rd_d    = hi_rd_q;
            we_d    = 1'b1;
            state_d = IDLE;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         hi_rd_q   <= '0;
         out_valid <= 1'b0;
         out_we    <= 1'b0;
         out_rd    <= '0;
         out_data  <= '0;
         flags     <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         hi_rd_q   <= hi_rd_d;
         out_valid <= valid_d;
         out_we    <= we_d;
         out_rd    <= rd_d;
         out_data  <= data_d;
         flags     <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural ALU model.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a, in_b;
   logic [4:0]  in_rd;
   logic [31:0] alu_x, alu_y;
   logic        alu_carry;
   logic [31:0] alu_summ, alu_mult_h, alu_mult_l, alu_zand, alu_zor, alu_zxor, alu_znot;
   logic [31:0] alu_sub, alu_ashiftl, alu_ashiftr, alu_lshiftl, alu_lshiftr, alu_revers;
   logic        alu_ocarry;
   logic        out_valid, out_ready, out_we;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [3:0]  flags;

   int n_checks = 0;
   int n_fail   = 0;
   int n_acc    = 0;

   always #5 clk = ~clk;

   alu_exec_stage #(.XLEN(32), .RD_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .alu_x(alu_x), .alu_y(alu_y), .alu_carry(alu_carry),
      .alu_summ(alu_summ), .alu_mult_h(alu_mult_h), .alu_mult_l(alu_mult_l),
      .alu_zand(alu_zand), .alu_zor(alu_zor), .alu_zxor(alu_zxor), .alu_znot(alu_znot),
      .alu_sub(alu_sub), .alu_ashiftl(alu_ashiftl), .alu_ashiftr(alu_ashiftr),
      .alu_lshiftl(alu_lshiftl), .alu_lshiftr(alu_lshiftr), .alu_revers(alu_revers),
      .alu_ocarry(alu_ocarry),
      .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
      .out_rd(out_rd), .out_data(out_data), .flags(flags)
   );

   // Behavioural ALU: adder with carry-in, subtractor borrowing ~carry in SBC mode, signed multiply
   logic signed [63:0] prod;
   always_comb begin
      {alu_ocarry, alu_summ} = {1'b0, alu_x} + {1'b0, alu_y} + 33'(alu_carry);
      alu_sub     = alu_x - alu_y - 32'((in_op == 4'd3) && !alu_carry);
      prod        = $signed({{32{alu_x[31]}}, alu_x}) * $signed({{32{alu_y[31]}}, alu_y});
      alu_mult_h  = prod[63:32];
      alu_mult_l  = prod[31:0];
      alu_zand    = alu_x & alu_y;
      alu_zor     = alu_x | alu_y;
      alu_zxor    = alu_x ^ alu_y;
      alu_znot    = ~alu_x;
      alu_ashiftl = alu_x << alu_y;
      alu_ashiftr = 32'($signed(alu_x) >>> alu_y);
      alu_lshiftl = alu_x << alu_y;
      alu_lshiftr = alu_x >> alu_y;
      for (int i = 0; i < 32; i++) alu_revers[i] = alu_x[31-i];
   end

   // Count issue handshakes
   always @(posedge clk) if (!rst && in_valid && in_ready) n_acc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one beat at negedge, check ready and carry-in, take the edge
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic cin);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
      #1;
      check("in_ready", 64'(in_ready), 64'd1);
      check("alu_carry", 64'(alu_carry), 64'(cin));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] data, input logic [3:0] fl);
      check({tag, ".valid"}, 64'(out_valid), 64'd1);
      check({tag, ".we"},    64'(out_we),    64'(we));
      check({tag, ".rd"},    64'(out_rd),    64'(rd));
      check({tag, ".data"},  64'(out_data),  64'(data));
      check({tag, ".flags"}, 64'(flags),     64'(fl));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.data",  64'(out_data),  64'd0);
      check("rst.rd",    64'(out_rd),    64'd0);
      check("rst.flags", 64'(flags),     64'd0);
      check("rst.ready", 64'(in_ready),  64'd1);

      issue(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b0);            // ADD -> 0, Z C
      expect_out("add_wrap", 1'b1, 5'd3, 32'd0, 4'b1010);
      issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd4, 1'b0);            // ADD overflow
      expect_out("add_ovf", 1'b1, 5'd4, 32'h8000_0000, 4'b0101);
      issue(4'd1, 32'd0, 32'd0, 5'd5, 1'b0);                    // ADC with C=0
      expect_out("adc0", 1'b1, 5'd5, 32'd0, 4'b1000);
      issue(4'd15, 32'd3, 32'd5, 5'd6, 1'b0);                   // CMP 3,5
      expect_out("cmp", 1'b0, 5'd6, 32'hFFFF_FFFE, 4'b0100);
      issue(4'd3, 32'd10, 32'd2, 5'd7, 1'b0);                   // SBC with borrow
      expect_out("sbc", 1'b1, 5'd7, 32'd7, 4'b0010);
      issue(4'd14, 32'd0, 32'h0000_1234, 5'd8, 1'b0);           // MOV keeps flags
      expect_out("mov", 1'b1, 5'd8, 32'h0000_1234, 4'b0010);
      issue(4'd1, 32'd5, 32'd6, 5'd9, 1'b1);                    // ADC with C=1
      expect_out("adc1", 1'b1, 5'd9, 32'd12, 4'b0000);
      issue(4'd9, 32'h8000_0000, 32'd4, 5'd10, 1'b0);           // ASR
      expect_out("asr", 1'b1, 5'd10, 32'hF800_0000, 4'b0100);
      issue(4'd11, 32'h8000_0000, 32'd31, 5'd11, 1'b0);         // LSR
      expect_out("lsr", 1'b1, 5'd11, 32'd1, 4'b0000);
      issue(4'd12, 32'd1, 32'd0, 5'd12, 1'b0);                  // REV
      expect_out("rev", 1'b1, 5'd12, 32'h8000_0000, 4'b0100);
      issue(4'd6, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 5'd13, 1'b0);   // XOR -> 0
      expect_out("xor", 1'b1, 5'd13, 32'd0, 4'b1000);

      issue(4'd13, 32'hFFFF_FFFE, 32'd3, 5'd31, 1'b0);          // MUL -2*3
      expect_out("mul.lo", 1'b1, 5'd31, 32'hFFFF_FFFA, 4'b0100);
      check("mul.ready_lo", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      expect_out("mul.hi", 1'b1, 5'd0, 32'hFFFF_FFFF, 4'b0100);
      check("mul.ready_hi", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      check("mul.drain", 64'(out_valid), 64'd0);

      // Writeback stall with issue held valid
      out_ready = 1'b0;
      n_acc = 0;
      issue(4'd0, 32'd1, 32'd2, 5'd4, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_op = 4'd5; in_a = 32'h0000_00F0; in_b = 32'h0000_000F; in_rd = 5'd9;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("stall.data",  64'(out_data),  64'd3);
         check("stall.rd",    64'(out_rd),    64'd4);
         check("stall.valid", 64'(out_valid), 64'd1);
         check("stall.ready", 64'(in_ready),  64'd0);
      end
      check("stall.acc", 64'(n_acc), 64'd1);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      expect_out("stall.or", 1'b1, 5'd9, 32'h0000_00FF, 4'b0000);
      @(posedge clk); #1;
      check("stall.acc2", 64'(n_acc), 64'd2);
      check("stall.drain", 64'(out_valid), 64'd0);

      // Reset while the hi beat is pending
      out_ready = 1'b0;
      issue(4'd13, 32'd2, 32'hFFFF_FFFF, 5'd5, 1'b0);
      check("mrst.ready", 64'(in_ready), 64'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("mrst.valid", 64'(out_valid), 64'd0);
      check("mrst.flags", 64'(flags),     64'd0);
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("mrst.nohi", 64'(out_valid), 64'd0);
      end
      check("mrst.ready2", 64'(in_ready), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
